// File: rtl/adder_pkg.sv
// Shared sizing constants for the integer add primitive.
package adder_pkg;

  localparam int unsigned ADD_WIDTH   = 32;
  localparam int unsigned ADD_GROUP   = 4;
  localparam int unsigned ADD_NGROUPS = ADD_WIDTH / ADD_GROUP;

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead group: local carries, sum bits, and group propagate/generate.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       P,
  output logic       G
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // Flattened lookahead: every carry is a direct sum of products of c_in.
  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);

  assign s = p ^ c;
  assign P = &p;
  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/adder_32.sv
// 32-bit two-level carry-lookahead adder with combinational and registered results.
module adder_32
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_WIDTH,
  parameter int unsigned GROUP = ADD_GROUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q
);

  localparam int unsigned NGroups = WIDTH / GROUP;

  if (GROUP != ADD_GROUP || NGroups != ADD_NGROUPS || WIDTH % GROUP != 0) begin : g_bad_cfg
    $error("adder_32: only WIDTH=32, GROUP=4 is supported");
  end

  logic [NGroups-1:0] grp_p;
  logic [NGroups-1:0] grp_g;
  logic [NGroups:0]   grp_c;

  for (genvar gi = 0; gi < NGroups; gi++) begin : g_grp
    cla4 u_cla4 (
      .a    (a[gi*GROUP +: GROUP]),
      .b    (b[gi*GROUP +: GROUP]),
      .c_in (grp_c[gi]),
      .s    (sum[gi*GROUP +: GROUP]),
      .P    (grp_p[gi]),
      .G    (grp_g[gi])
    );
  end

  // Each group carry-in is an independent sum of products over cin and lower
  // group P/G terms; the loops unroll into parallel logic, not a ripple chain.
  always_comb begin
    logic term;
    grp_c = '0;
    term  = 1'b0;
    for (int k = 0; k <= int'(NGroups); k++) begin
      term = cin;
      for (int m = 0; m < k; m++) begin
        term = term & grp_p[m];
      end
      grp_c[k] = term;
      for (int j = 0; j < k; j++) begin
        term = grp_g[j];
        for (int m = j + 1; m < k; m++) begin
          term = term & grp_p[m];
        end
        grp_c[k] = grp_c[k] | term;
      end
    end
  end

  // Top entry expands to G_all | (P_all & cin).
  assign cout = grp_c[NGroups];
  assign ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= sum;
      cout_q <= cout;
      ovf_q  <= ovf;
    end
  end

endmodule

// File: tb/tb_adder_32.sv
// Self-checking bench for adder_32: directed corners, random operands, registered path.
module tb_adder_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic [31:0] sum_q;
  logic        cout_q;
  logic        ovf_q;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  adder_32 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .sum    (sum),
    .cout   (cout),
    .ovf    (ovf),
    .sum_q  (sum_q),
    .cout_q (cout_q),
    .ovf_q  (ovf_q)
  );

  // Reference: exact integer sum, signed overflow judged by range of the true signed result.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic c);
    longint unsigned u;
    longint          s;
    logic            o;
    u = longint'(x) + longint'(y) + longint'(c);
    s = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
    o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {o, u[32:0]};
  endfunction

  task automatic test_reset();
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b1;
    #1;
    checks++;
    if ({sum_q, cout_q, ovf_q} !== 34'd0) begin
      errors++;
      $display("FAIL reset_regs: got sum_q=%h cout_q=%b ovf_q=%b want 0", sum_q, cout_q, ovf_q);
    end
    @(posedge clk); #1;
    checks++;
    if ({sum_q, cout_q, ovf_q} !== 34'd0) begin
      errors++;
      $display("FAIL reset_hold: got sum_q=%h cout_q=%b ovf_q=%b want 0", sum_q, cout_q, ovf_q);
    end
    checks++;
    if ({cout, sum} !== 33'h1_0000_0001) begin
      errors++;
      $display("FAIL reset_comb: got cout=%b sum=%h want 1/00000001", cout, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic        vc [5];
    logic [33:0] ve [5];
    va[0] = 32'h0000_0000; vb[0] = 32'h0000_0000; vc[0] = 1'b0; ve[0] = {1'b0, 1'b0, 32'h0000_0000};
    va[1] = 32'hFFFF_FFFF; vb[1] = 32'hFFFF_FFFF; vc[1] = 1'b0; ve[1] = {1'b0, 1'b1, 32'hFFFF_FFFE};
    va[2] = 32'hFFFF_FFFF; vb[2] = 32'h0000_0000; vc[2] = 1'b1; ve[2] = {1'b0, 1'b1, 32'h0000_0000};
    va[3] = 32'h7FFF_FFFF; vb[3] = 32'h0000_0001; vc[3] = 1'b0; ve[3] = {1'b1, 1'b0, 32'h8000_0000};
    va[4] = 32'h8000_0000; vb[4] = 32'h8000_0000; vc[4] = 1'b0; ve[4] = {1'b1, 1'b1, 32'h0000_0000};
    for (int i = 0; i < 5; i++) begin
      a = va[i]; b = vb[i]; cin = vc[i];
      #5;
      checks++;
      if ({ovf, cout, sum} !== ve[i]) begin
        errors++;
        $display("FAIL directed_%0d: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                 i, ovf, cout, sum, ve[i][33], ve[i][32], ve[i][31:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [33:0] exp;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a   = $urandom();
      b   = $urandom();
      cin = i[0];
      exp = model(a, b, cin);
      #5;
      checks++;
      if ({cout, sum} !== exp[32:0]) begin
        errors++;
        $display("FAIL rand_sum_%0d: a=%h b=%h cin=%b got %b_%h want %b_%h",
                 i, a, b, cin, cout, sum, exp[32], exp[31:0]);
      end
      checks++;
      if (ovf !== exp[33]) begin
        errors++;
        $display("FAIL rand_ovf_%0d: a=%h b=%h cin=%b got %b want %b", i, a, b, cin, ovf, exp[33]);
      end
      @(posedge clk); #1;
      checks++;
      if ({ovf_q, cout_q, sum_q} !== exp) begin
        errors++;
        $display("FAIL rand_reg_%0d: got ovf_q=%b cout_q=%b sum_q=%h want %b %b %h",
                 i, ovf_q, cout_q, sum_q, exp[33], exp[32], exp[31:0]);
      end
    end
  endtask

  task automatic test_registered();
    logic [33:0] exp;
    // Make sure the register holds something non-zero before the async reset.
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; cin = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sum_q, cout_q, ovf_q} !== 34'd0) begin
      errors++;
      $display("FAIL async_reset: got sum_q=%h cout_q=%b ovf_q=%b want 0", sum_q, cout_q, ovf_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ovf_q, cout_q, sum_q} !== {1'b0, 1'b0, 32'h2345_678A}) begin
      errors++;
      $display("FAIL reg_capture: got ovf_q=%b cout_q=%b sum_q=%h want 0 0 2345678a",
               ovf_q, cout_q, sum_q);
    end
    // Mid-cycle input change must not reach the register before the next edge.
    a = 32'h7FFF_FFFF; b = 32'h0000_0001; cin = 1'b0;
    exp = model(a, b, cin);
    #4;
    checks++;
    if (sum_q !== 32'h2345_678A) begin
      errors++;
      $display("FAIL reg_hold: got sum_q=%h want 2345678a", sum_q);
    end
    @(posedge clk); #1;
    checks++;
    if ({ovf_q, cout_q, sum_q} !== exp) begin
      errors++;
      $display("FAIL reg_next: got ovf_q=%b cout_q=%b sum_q=%h want %b %b %h",
               ovf_q, cout_q, sum_q, exp[33], exp[32], exp[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_registered();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
